// File: rtl/datapath_pkg.sv
// Shared datapath definitions: pipeline-stage state encoding and the default data width
// used by the selector blocks.
package datapath_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

endpackage

// File: rtl/mux_n_1_pipe_if.sv
// Valid/ready bundle for the registered N:1 selector; the master side drives the
// upstream offer and the downstream ready, the slave side is the pipeline stage itself.
interface mux_n_1_pipe_if
  import datapath_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int N_INPUTS = 4
);

  localparam int SEL_W = $clog2(N_INPUTS);

  logic                      flush;
  logic [N_INPUTS*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_sel_err;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output flush, in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_sel_err, out_valid
  );

  modport slave (
    input  flush, in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_sel_err, out_valid
  );

endinterface

// File: rtl/mux_n_1_comb.sv
// Purely combinational N:1 selector; codes with no matching input return DEFAULT_VALUE
// and raise err, so unused selector values never produce X.
module mux_n_1_comb
  import datapath_pkg::*;
#(
  parameter int                 WIDTH         = DEFAULT_WIDTH,
  parameter int                 N_INPUTS      = 4,
  parameter logic [WIDTH-1:0]   DEFAULT_VALUE = '0,
  parameter int                 SEL_W         = $clog2(N_INPUTS)
) (
  input  logic [N_INPUTS*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          y,
  output logic                      err
);

  always_comb begin
    y   = DEFAULT_VALUE;
    err = 1'b1;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (sel == SEL_W'(k)) begin
        y   = data[k*WIDTH +: WIDTH];
        err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_1_pipe.sv
// Registered N:1 selector with a two-entry (output + skid) valid/ready stage, so operand
// or write-back selection can sit on a pipeline boundary without a combinational path.
module mux_n_1_pipe
  import datapath_pkg::*;
#(
  parameter int               WIDTH         = DEFAULT_WIDTH,
  parameter int               N_INPUTS      = 4,
  parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0
) (
  input logic            clk,
  input logic            reset,
  mux_n_1_pipe_if.slave  bus
);

  localparam int SEL_W = $clog2(N_INPUTS);

  logic [1:0]                state, state_nxt;
  logic                      in_ready_q;
  logic [WIDTH-1:0]          out_data_q;
  logic [SEL_W-1:0]          out_sel_q;
  logic                      out_err_q;
  logic [N_INPUTS*WIDTH-1:0] skid_data;
  logic [SEL_W-1:0]          skid_sel;

  logic [WIDTH-1:0]          in_y, skid_y;
  logic                      in_err, skid_err;
  logic                      out_valid, accept, consume;
  logic                      load_in, load_skid, load_skid_to_out;

  // The skid keeps the raw input vector; its selection is resolved when it moves to OUT.
  mux_n_1_comb #(
    .WIDTH(WIDTH), .N_INPUTS(N_INPUTS), .DEFAULT_VALUE(DEFAULT_VALUE), .SEL_W(SEL_W)
  ) u_in_mux (
    .data(bus.in_data), .sel(bus.in_sel), .y(in_y), .err(in_err)
  );

  mux_n_1_comb #(
    .WIDTH(WIDTH), .N_INPUTS(N_INPUTS), .DEFAULT_VALUE(DEFAULT_VALUE), .SEL_W(SEL_W)
  ) u_skid_mux (
    .data(skid_data), .sel(skid_sel), .y(skid_y), .err(skid_err)
  );

  assign out_valid = (state != ST_EMPTY);
  assign accept    = bus.in_valid && in_ready_q;
  assign consume   = out_valid && bus.out_ready;

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = out_data_q;
  assign bus.out_sel     = out_sel_q;
  assign bus.out_sel_err = out_err_q;

  always_comb begin
    state_nxt        = state;
    load_in          = 1'b0;
    load_skid        = 1'b0;
    load_skid_to_out = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          load_in   = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          load_in = 1'b1;
        end else if (consume) begin
          state_nxt = ST_EMPTY;
        end else if (accept) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end
      end
      ST_FULL: begin
        if (consume) begin
          state_nxt        = ST_ONE;
          load_skid_to_out = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush empties the stage but leaves the data registers untouched.
    if (bus.flush) begin
      state_nxt        = ST_EMPTY;
      load_in          = 1'b0;
      load_skid        = 1'b0;
      load_skid_to_out = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      out_data_q <= '0;
      out_sel_q  <= '0;
      out_err_q  <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_FULL);
      if (load_in) begin
        out_data_q <= in_y;
        out_sel_q  <= bus.in_sel;
        out_err_q  <= in_err;
      end else if (load_skid_to_out) begin
        out_data_q <= skid_y;
        out_sel_q  <= skid_sel;
        out_err_q  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= bus.in_data;
        skid_sel  <= bus.in_sel;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Bench for mux_n_1_pipe: directed scenarios on a 4-input and a 3-input instance, then
// randomized valid/ready/flush traffic against a two-entry FIFO reference model.
module tb_mux_n_1_pipe;
  import datapath_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
    logic         err;
  } word_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_n_1_pipe_if #(.WIDTH(W), .N_INPUTS(4)) if4 ();
  mux_n_1_pipe_if #(.WIDTH(W), .N_INPUTS(3)) if3 ();

  mux_n_1_pipe #(.WIDTH(W), .N_INPUTS(4), .DEFAULT_VALUE(32'h0)) dut4 (
    .clk(clk), .reset(reset), .bus(if4.slave)
  );

  mux_n_1_pipe #(.WIDTH(W), .N_INPUTS(3), .DEFAULT_VALUE(32'hDEAD_BEEF)) dut3 (
    .clk(clk), .reset(reset), .bus(if3.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", if4.out_valid); end
    checks++; if (if4.out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", if4.out_data); end
    checks++; if (if4.out_sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_out_sel: got %0d expected 0", if4.out_sel); end
    checks++; if (if4.out_sel_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_sel_err: got %b expected 0", if4.out_sel_err); end
    checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", if4.in_ready); end
    checks++; if (if3.in_ready !== 1'b1 || if3.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dut3: got ready=%b valid=%b expected 1/0", if3.in_ready, if3.out_valid); end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    if4.out_ready = 1'b1;
    if4.in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    if4.in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if4.in_sel = 2'(k);
      tick();
      checks++; if (if4.out_valid !== 1'b1 || if4.out_data !== 32'hA0 + k) begin errors++; $display("[TB] FAIL stream_data[%0d]: got valid=%b data=%h expected 1/%h", k, if4.out_valid, if4.out_data, 32'hA0 + k); end
      checks++; if (if4.out_sel !== 2'(k) || if4.out_sel_err !== 1'b0) begin errors++; $display("[TB] FAIL stream_sel[%0d]: got sel=%0d err=%b expected %0d/0", k, if4.out_sel, if4.out_sel_err, k); end
      checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_in_ready[%0d]: got %b expected 1", k, if4.in_ready); end
    end
    if4.in_valid = 1'b0;
    tick();
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain: got valid=%b expected 0", if4.out_valid); end
  endtask

  task automatic test_backpressure();
    if4.out_ready = 1'b0;
    if4.in_sel    = 2'd0;
    if4.in_valid  = 1'b1;
    if4.in_data   = {96'h0, 32'h11};
    tick();
    if4.in_data = {96'h0, 32'h22};
    tick();
    // Stage full: a further offer must be ignored.
    if4.in_data = {96'h0, 32'h33};
    checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready_low: got %b expected 0", if4.in_ready); end
    checks++; if (if4.out_valid !== 1'b1 || if4.out_data !== 32'h11) begin errors++; $display("[TB] FAIL bp_hold: got valid=%b data=%h expected 1/11", if4.out_valid, if4.out_data); end
    tick();
    checks++; if (if4.out_data !== 32'h11 || if4.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall: got data=%h ready=%b expected 11/0", if4.out_data, if4.in_ready); end
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    tick();
    checks++; if (if4.out_valid !== 1'b1 || if4.out_data !== 32'h22) begin errors++; $display("[TB] FAIL bp_second: got valid=%b data=%h expected 1/22", if4.out_valid, if4.out_data); end
    checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_in_ready_rise: got %b expected 1", if4.in_ready); end
    tick();
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_extra: got valid=%b data=%h expected valid 0", if4.out_valid, if4.out_data); end
  endtask

  task automatic test_out_of_range();
    if3.out_ready = 1'b1;
    if3.in_data   = {32'h0000_C0DE, 32'h1111_1111, 32'h2222_2222};
    if3.in_valid  = 1'b1;
    if3.in_sel    = 2'd3;
    tick();
    checks++; if (if3.out_valid !== 1'b1 || if3.out_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL oor_data: got valid=%b data=%h expected 1/deadbeef", if3.out_valid, if3.out_data); end
    checks++; if (if3.out_sel !== 2'd3 || if3.out_sel_err !== 1'b1) begin errors++; $display("[TB] FAIL oor_sel_err: got sel=%0d err=%b expected 3/1", if3.out_sel, if3.out_sel_err); end
    if3.in_sel = 2'd2;
    tick();
    checks++; if (if3.out_data !== 32'h0000_C0DE || if3.out_sel_err !== 1'b0) begin errors++; $display("[TB] FAIL oor_top_in_range: got data=%h err=%b expected 0000c0de/0", if3.out_data, if3.out_sel_err); end
    if3.in_valid = 1'b0;
    tick();
    checks++; if (if3.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL oor_drain: got valid=%b expected 0", if3.out_valid); end
  endtask

  task automatic test_flush();
    if4.out_ready = 1'b0;
    if4.in_sel    = 2'd1;
    if4.in_valid  = 1'b1;
    if4.in_data   = {64'h0, 32'h55, 32'h0};
    tick();
    if4.in_data = {64'h0, 32'h66, 32'h0};
    tick();
    if4.flush   = 1'b1;
    if4.in_data = {64'h0, 32'h77, 32'h0};
    tick();
    if4.flush    = 1'b0;
    if4.in_valid = 1'b0;
    checks++; if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_full: got valid=%b ready=%b expected 0/1", if4.out_valid, if4.in_ready); end
    if4.out_ready = 1'b1;
    tick();
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_full_no_emit: got valid=%b data=%h expected valid 0", if4.out_valid, if4.out_data); end
    // Flush with one word held and an input that would otherwise be accepted.
    if4.out_ready = 1'b0;
    if4.in_valid  = 1'b1;
    if4.in_data   = {64'h0, 32'h88, 32'h0};
    tick();
    if4.flush   = 1'b1;
    if4.in_data = {64'h0, 32'h99, 32'h0};
    tick();
    if4.flush    = 1'b0;
    if4.in_valid = 1'b0;
    checks++; if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_one: got valid=%b ready=%b expected 0/1", if4.out_valid, if4.in_ready); end
    checks++; if (if4.out_data !== 32'h88) begin errors++; $display("[TB] FAIL flush_keeps_data: got %h expected 88", if4.out_data); end
    if4.out_ready = 1'b1;
    tick();
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_one_no_emit: got valid=%b data=%h expected valid 0", if4.out_valid, if4.out_data); end
  endtask

  task automatic test_reset_mid();
    if4.out_ready = 1'b0;
    if4.in_sel    = 2'd2;
    if4.in_valid  = 1'b1;
    if4.in_data   = {32'h0, 32'h5A5A_0011, 64'h0};
    tick();
    if4.in_data = {32'h0, 32'h5A5A_0022, 64'h0};
    tick();
    if4.in_valid = 1'b0;
    checks++; if (if4.in_ready !== 1'b0 || if4.out_data !== 32'h5A5A_0011) begin errors++; $display("[TB] FAIL mid_reset_setup: got ready=%b data=%h expected 0/5a5a0011", if4.in_ready, if4.out_data); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (if4.out_valid !== 1'b0 || if4.out_data !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset_out: got valid=%b data=%h expected 0/0", if4.out_valid, if4.out_data); end
    checks++; if (if4.in_ready !== 1'b1 || if4.out_sel !== 2'd0) begin errors++; $display("[TB] FAIL mid_reset_ready: got ready=%b sel=%0d expected 1/0", if4.in_ready, if4.out_sel); end
    tick();
    reset = 1'b0;
    if4.out_ready = 1'b1;
    tick();
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_skid_cleared: got valid=%b data=%h expected valid 0", if4.out_valid, if4.out_data); end
  endtask

  task automatic test_random();
    word_t q[$];
    word_t w;
    int    cycles = 0;
    int    words  = 0;
    int    sz;
    bit    cons, acc;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    while (words < 10000 && cycles < 60000) begin
      sz = q.size();
      checks++; if (if4.out_valid !== (sz != 0)) begin errors++; if (errors < 20) $display("[TB] FAIL rand_out_valid @%0d: got %b expected %b", cycles, if4.out_valid, sz != 0); end
      checks++; if (if4.in_ready !== (sz < 2)) begin errors++; if (errors < 20) $display("[TB] FAIL rand_in_ready @%0d: got %b expected %b", cycles, if4.in_ready, sz < 2); end
      if (sz != 0) begin
        checks++; if ({if4.out_data, if4.out_sel, if4.out_sel_err} !== q[0]) begin errors++; if (errors < 20) $display("[TB] FAIL rand_word @%0d: got %h/%0d/%b expected %h/%0d/%b", cycles, if4.out_data, if4.out_sel, if4.out_sel_err, q[0].data, q[0].sel, q[0].err); end
      end
      if4.in_valid = ($urandom_range(0, 3) != 0);
      if (((cycles / 200) % 3) == 0) if4.out_ready = ($urandom_range(0, 3) == 0);
      else                           if4.out_ready = ($urandom_range(0, 3) != 0);
      if4.flush   = ($urandom_range(0, 99) == 0);
      if4.in_sel  = 2'($urandom_range(0, 3));
      if4.in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      cons = (sz != 0) && if4.out_ready;
      acc  = if4.in_valid && (sz < 2);
      if (cons) begin
        void'(q.pop_front());
        words++;
      end
      if (if4.flush) begin
        q.delete();
      end else if (acc) begin
        w.data = W'(if4.in_data >> (W * int'(if4.in_sel)));
        w.sel  = if4.in_sel;
        w.err  = 1'b0;
        q.push_back(w);
      end
      tick();
      cycles++;
    end
    if4.in_valid = 1'b0;
    if4.flush    = 1'b0;
    checks++; if (words < 10000) begin errors++; $display("[TB] FAIL rand_timeout: got %0d words expected 10000 within 60000 cycles", words); end
  endtask

  initial begin
    reset          = 1'b0;
    if4.flush      = 1'b0;
    if4.in_data    = '0;
    if4.in_sel     = '0;
    if4.in_valid   = 1'b0;
    if4.out_ready  = 1'b0;
    if3.flush      = 1'b0;
    if3.in_data    = '0;
    if3.in_sel     = '0;
    if3.in_valid   = 1'b0;
    if3.out_ready  = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_out_of_range();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
